// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU issue controller: MIPS opcode/funct values,
// FSM state encoding, flag bit positions and the instruction decoder.
package alu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OPR  = 2'd1;
  localparam logic [1:0] S_EXE  = 2'd2;

  localparam int FLG_ZERO = 2;
  localparam int FLG_NEG  = 1;
  localparam int FLG_OVF  = 0;

  typedef struct packed {
    logic       wr;       // instruction writes a GPR
    logic [4:0] waddr;
    logic       ovf_chk;  // trapping arithmetic: overflow suppresses the write
    logic       br;
    logic       br_ne;
    logic       mem;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d = '0;
    case (instr[31:26])
      OP_RTYPE: begin
        d.waddr = instr[15:11];
        case (instr[5:0])
          F_ADD, F_SUB: begin
            d.wr      = 1'b1;
            d.ovf_chk = 1'b1;
          end
          F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA: d.wr = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin
        d.wr      = 1'b1;
        d.ovf_chk = 1'b1;
        d.waddr   = instr[20:16];
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        d.wr    = 1'b1;
        d.waddr = instr[20:16];
      end
      OP_BEQ: d.br = 1'b1;
      OP_BNE: begin
        d.br    = 1'b1;
        d.br_ne = 1'b1;
      end
      OP_LW, OP_SW: d.mem = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// General-purpose register file: two async operand reads, one async debug read,
// one synchronous write port. r0 is hard-wired to zero.
module alu_regfile #(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [31:0]   rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [31:0]   rdata_b_o,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [31:0]   dbg_data_o
);

  logic [31:0] mem_q [NREG];

  // NOTE: the array is built from flops with an async reset so every GPR reads 0
  // after reset; a RAM macro could not be cleared this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = (raddr_a_i  == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o  = (raddr_b_i  == '0) ? '0 : mem_q[raddr_b_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one MIPS instruction at a time to an external combinational ALU and
// retires its result as a register write, branch outcome or memory address.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int          NREG   = 32,
  parameter logic [31:0] RST_PC = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [31:0] alu_instr,
  output logic [31:0] alu_regA,
  output logic [31:0] alu_regB,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        br_valid,
  output logic        br_taken,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic        ovf_err,
  output logic [2:0]  flags_q,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam int AW = $clog2(NREG);

  if (RST_PC != '0) begin : g_rst_pc_chk
    $error("alu_issue_ctrl: RST_PC is unused and must stay 0");
  end

  logic [1:0]  state_q, state_d;
  logic [31:0] instr_q;
  logic [31:0] alu_instr_q, alu_rega_q, alu_regb_q;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_addr_q;
  logic [31:0] wb_data_q;
  logic        br_valid_q, br_valid_d, br_taken_q, br_taken_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q;
  logic        ovf_err_q, ovf_err_d;
  dec_t        dec;
  logic        exe;

  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [31:0]   rf_wdata, rf_rdata_a, rf_rdata_b;

  assign in_ready = (state_q == S_IDLE) & ~cfg_we;

  // NOTE: every signal written here gets a default first, so no latch is inferred
  // for the paths that do not assign it.
  always_comb begin
    state_d     = state_q;
    dec         = decode(alu_instr_q);
    exe         = (state_q == S_EXE);
    ovf_err_d   = exe & dec.ovf_chk & alu_flags[FLG_OVF];
    wb_valid_d  = exe & dec.wr & ~ovf_err_d & (dec.waddr != '0);
    br_valid_d  = exe & dec.br;
    br_taken_d  = dec.br_ne ? ~alu_flags[FLG_ZERO] : alu_flags[FLG_ZERO];
    mem_valid_d = exe & dec.mem;
    case (state_q)
      S_IDLE:  if (in_valid && in_ready) state_d = S_OPR;
      S_OPR:   state_d = S_EXE;
      S_EXE:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      alu_instr_q <= '0;
      alu_rega_q  <= '0;
      alu_regb_q  <= '0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      br_valid_q  <= 1'b0;
      br_taken_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      ovf_err_q   <= 1'b0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      wb_valid_q  <= wb_valid_d;
      br_valid_q  <= br_valid_d;
      mem_valid_q <= mem_valid_d;
      ovf_err_q   <= ovf_err_d;
      if (in_valid && in_ready) instr_q <= in_instr;
      if (state_q == S_OPR) begin
        alu_instr_q <= instr_q;
        alu_rega_q  <= rf_rdata_a;
        alu_regb_q  <= rf_rdata_b;
      end
      if (exe) flags_q <= alu_flags;
      if (wb_valid_d) begin
        wb_addr_q <= dec.waddr;
        wb_data_q <= alu_result;
      end
      if (br_valid_d)  br_taken_q <= br_taken_d;
      if (mem_valid_d) mem_addr_q <= alu_result;
    end
  end

  // The GPR write lands on the edge that ends the wb_valid cycle, still ahead of
  // the next instruction's operand read. A cfg write colliding with it is dropped.
  assign rf_we    = wb_valid_q | (cfg_we & (state_q == S_IDLE));
  assign rf_waddr = wb_valid_q ? wb_addr_q[AW-1:0] : cfg_addr[AW-1:0];
  assign rf_wdata = wb_valid_q ? wb_data_q : cfg_data;

  alu_regfile #(.NREG(NREG), .AW(AW)) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (rf_we),
    .waddr_i    (rf_waddr),
    .wdata_i    (rf_wdata),
    .raddr_a_i  (instr_q[21 +: AW]),
    .rdata_a_o  (rf_rdata_a),
    .raddr_b_i  (instr_q[16 +: AW]),
    .rdata_b_o  (rf_rdata_b),
    .dbg_addr_i (dbg_addr[AW-1:0]),
    .dbg_data_o (dbg_data)
  );

  assign alu_instr = alu_instr_q;
  assign alu_regA  = alu_rega_q;
  assign alu_regB  = alu_regb_q;
  assign wb_valid  = wb_valid_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign br_valid  = br_valid_q;
  assign br_taken  = br_taken_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign ovf_err   = ovf_err_q;

endmodule
